// File: rtl/mul8_seq_if.sv
// Operand/result handshake bundle between the I/O wrapper and mul8_seq_ctrl.
// The master side issues operand pairs and consumes products.
interface mul8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply sequenced over an external 4x4 core, one nibble pair per cycle.
// state | meaning
// IDLE  | waiting for operands
// STEP  | driving core with nibble pair k, accumulating its shifted product
// DONE  | product presented on p until taken; may accept the next pair at once
module mul8_seq_ctrl #(
    parameter logic ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    mul8_seq_if.slave   bus,
    output logic        busy,
    output logic [7:0]  ops_count,
    output logic [3:0]  mul_m,
    output logic [3:0]  mul_q,
    input  logic [7:0]  mul_p
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc;
    logic [1:0]  k;
    logic [3:0]  mask;
    logic [15:0] p_r;

    logic        accept;
    logic [3:0]  load_mask;
    logic [15:0] partial;
    logic [15:0] acc_next;
    logic [3:0]  mask_left;

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else if (m[3]) idx = 2'd3;
        return idx;
    endfunction

    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.p         = p_r;
    assign busy          = (state != S_IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // Bit k marks step k: 0 = lo*lo, 1 = hi(a)*lo(b), 2 = lo(a)*hi(b), 3 = hi*hi.
    always_comb begin
        load_mask = 4'hF;
        if (ZERO_SKIP) begin
            load_mask[0] = (|bus.a[3:0]) && (|bus.b[3:0]);
            load_mask[1] = (|bus.a[7:4]) && (|bus.b[3:0]);
            load_mask[2] = (|bus.a[3:0]) && (|bus.b[7:4]);
            load_mask[3] = (|bus.a[7:4]) && (|bus.b[7:4]);
        end
    end

    always_comb begin
        mul_m = 4'h0;
        mul_q = 4'h0;
        if (state == S_STEP) begin
            mul_m = k[0] ? a_r[7:4] : a_r[3:0];
            mul_q = k[1] ? b_r[7:4] : b_r[3:0];
        end
        case (k)
            2'd0:    partial = {8'h00, mul_p};
            2'd3:    partial = {mul_p, 8'h00};
            default: partial = {4'h0, mul_p, 4'h0};
        endcase
        acc_next  = acc + partial;
        mask_left = mask & ~(4'b0001 << k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            acc       <= 16'h0000;
            k         <= 2'd0;
            mask      <= 4'h0;
            p_r       <= 16'h0000;
            ops_count <= 8'h00;
        end else begin
            if ((state == S_DONE) && bus.out_ready) begin
                ops_count <= ops_count + 8'd1;
            end

            if (accept) begin
                a_r  <= bus.a;
                b_r  <= bus.b;
                acc  <= 16'h0000;
                mask <= load_mask;
                k    <= lowest_bit(load_mask);
                if (load_mask == 4'h0) begin
                    state <= S_DONE;
                    p_r   <= 16'h0000;
                end else begin
                    state <= S_STEP;
                end
            end else begin
                case (state)
                    S_STEP: begin
                        acc  <= acc_next;
                        mask <= mask_left;
                        if (mask_left != 4'h0) begin
                            k <= lowest_bit(mask_left);
                        end else begin
                            state <= S_DONE;
                            p_r   <= acc_next;
                        end
                    end
                    S_DONE: begin
                        if (bus.out_ready) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Randomised and directed bench for mul8_seq_ctrl with a queue scoreboard and
// an arithmetic reference model; a second instance covers ZERO_SKIP = 0.
module tb_mul8_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul8_seq_if bus1();
    mul8_seq_if bus0();

    logic       busy1, busy0;
    logic [7:0] ops1, ops0;
    logic [3:0] m1, q1, m0, q0;
    logic [7:0] core_p1, core_p0;

    // Behavioural 4x4 cores
    assign core_p1 = {4'h0, m1} * {4'h0, q1};
    assign core_p0 = {4'h0, m0} * {4'h0, q0};

    mul8_seq_ctrl #(.ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .ops_count(ops1),
        .mul_m(m1), .mul_q(q1), .mul_p(core_p1)
    );

    mul8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .ops_count(ops0),
        .mul_m(m0), .mul_q(q0), .mul_p(core_p0)
    );

    typedef struct {
        logic [15:0] p;
        int          due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] step_q[$];
    logic [7:0] exp_ops = 8'h00;
    bit         new_pres = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: product by plain arithmetic; core steps are the nonzero nibble
    // products in table order; out_valid follows the accept edge by that step count.
    task automatic push_expected(input logic [7:0] a, input logic [7:0] b);
        int am[4];
        int bm[4];
        int steps;
        am[0] = int'(a[3:0]); am[1] = int'(a[7:4]); am[2] = int'(a[3:0]); am[3] = int'(a[7:4]);
        bm[0] = int'(b[3:0]); bm[1] = int'(b[3:0]); bm[2] = int'(b[7:4]); bm[3] = int'(b[7:4]);
        steps = 0;
        for (int s = 0; s < 4; s++) begin
            if (am[s] * bm[s] != 0) begin
                step_q.push_back(8'(am[s] * 16 + bm[s]));
                steps++;
            end
        end
        exp_q.push_back('{p: 16'(int'(a) * int'(b)), due: cyc + 1 + steps});
    endtask

    task automatic tick(output bit accepted);
        @(negedge clk);
        accepted = bus1.in_valid && bus1.in_ready;
        if (accepted) push_expected(bus1.a, bus1.b);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy1 && !bus1.out_valid) begin
                if (step_q.size() == 0) fail_now("core_step_unexpected");
                else chk("core_nibbles", {24'h0, m1, q1}, {24'h0, step_q.pop_front()});
            end else begin
                chk("core_idle_zero", {24'h0, m1, q1}, 32'h0);
            end
            chk("ops_count", {24'h0, ops1}, {24'h0, exp_ops});
            if (bus1.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_valid_unexpected");
                end else begin
                    if (new_pres) chk("latency_cycle", cyc, exp_q[0].due);
                    chk("product", {16'h0, bus1.p}, {16'h0, exp_q[0].p});
                    if (bus1.out_ready) begin
                        void'(exp_q.pop_front());
                        exp_ops = exp_ops + 8'd1;
                    end
                end
            end
            new_pres = !bus1.out_valid || bus1.out_ready;
        end
    end

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy1) && n < 50) begin
            tick(acc);
            n++;
        end
        if (n == 50) fail_now("drain_timeout");
    endtask

    task automatic xact(input logic [7:0] a, input logic [7:0] b);
        bit acc;
        int n;
        bus1.a = a;
        bus1.b = b;
        bus1.in_valid = 1'b1;
        bus1.out_ready = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        if (!acc) fail_now("accept_timeout");
        bus1.in_valid = 1'b0;
        drain();
    endtask

    task automatic run_zs0(input logic [7:0] a, input logic [7:0] b);
        int start;
        int n;
        bus0.a = a;
        bus0.b = b;
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chk("zs0_in_ready", {31'h0, bus0.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        start = cyc;
        bus0.in_valid = 1'b0;
        n = 0;
        while (!bus0.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("zs0_latency", cyc - start, 4);
        chk("zs0_product", {16'h0, bus0.p}, 32'(int'(a) * int'(b)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rnib();
        return ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endfunction

    initial begin
        bit acc;
        int n;
        int cnt;
        bus1.in_valid = 1'b0; bus1.a = 8'h00; bus1.b = 8'h00; bus1.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = 8'h00; bus0.b = 8'h00; bus0.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, bus1.in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, bus1.out_valid}, 32'h0);
        chk("rst_p", {16'h0, bus1.p}, 32'h0);
        chk("rst_busy", {31'h0, busy1}, 32'h0);
        chk("rst_ops", {24'h0, ops1}, 32'h0);
        chk("rst_core", {24'h0, m1, q1}, 32'h0);
        chk("rst_zs0_busy", {31'h0, busy0}, 32'h0);
        rst_n = 1'b1;

        xact(8'hFF, 8'hFF);
        xact(8'h0A, 8'h00);
        xact(8'h10, 8'h01);

        // Consumer stalls; a different pair is offered throughout and must be ignored.
        bus1.a = 8'h12; bus1.b = 8'h34; bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin tick(acc); n++; end
        if (!acc) fail_now("hold_accept_timeout");
        bus1.a = 8'h77; bus1.b = 8'h99;
        n = 0;
        while (!bus1.out_valid && n < 10) begin tick(acc); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready", {31'h0, bus1.in_ready}, 32'h0);
            chk("hold_p", {16'h0, bus1.p}, 32'h03A8);
            tick(acc);
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        drain();

        // Reset while the core is being stepped.
        bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin tick(acc); n++; end
        bus1.in_valid = 1'b0;
        tick(acc);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy1}, 32'h0);
        chk("mid_rst_out_valid", {31'h0, bus1.out_valid}, 32'h0);
        chk("mid_rst_p", {16'h0, bus1.p}, 32'h0);
        chk("mid_rst_ops", {24'h0, ops1}, 32'h0);
        chk("mid_rst_core", {24'h0, m1, q1}, 32'h0);
        chk("mid_rst_in_ready", {31'h0, bus1.in_ready}, 32'h1);
        exp_q.delete();
        step_q.delete();
        exp_ops = 8'h00;
        new_pres = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("no_out_after_rst", {31'h0, bus1.out_valid}, 32'h0);
        end
        xact(8'h03, 8'h05);

        // Back-to-back random stream; 255 more products wraps ops_count to 0.
        bus1.a = {rnib(), rnib()};
        bus1.b = {rnib(), rnib()};
        bus1.in_valid = 1'b1;
        bus1.out_ready = 1'b1;
        cnt = 0;
        n = 0;
        while (cnt < 255 && n < 2000) begin
            tick(acc);
            n++;
            if (acc) begin
                cnt++;
                bus1.a = {rnib(), rnib()};
                bus1.b = {rnib(), rnib()};
            end
        end
        if (cnt < 255) fail_now("random_accept_timeout");
        bus1.in_valid = 1'b0;
        drain();
        chk("ops_wrap", {24'h0, ops1}, 32'h0);

        run_zs0(8'h0A, 8'h00);
        run_zs0(8'h12, 8'h34);
        run_zs0(8'hFF, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation time limit");
    end
endmodule
